// File: rtl/spi_master_ad9634_mc.sv
// rtl/spi_master_ad9634_mc.sv - SPI master for AD9634-class ADC register access
// Mode 0 frame: 16-bit instruction then DATA_W data bits, with SDIO turnaround on reads.
module spi_master_ad9634_mc #(
   parameter int CLK_DIV  = 4,
   parameter int DATA_W   = 8,
   parameter int NUM_CS   = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_rw,
   input  logic [12:0]             cmd_addr,
   input  logic [DATA_W-1:0]       cmd_wdata,
   input  logic [$clog2(NUM_CS):0] cmd_cs_sel,
   output logic                    rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    spi_sclk,
   output logic                    spi_mosi,
   output logic                    spi_mosi_oe,
   input  logic                    spi_miso,
   output logic [NUM_CS-1:0]       spi_cs_n
);
   localparam int N  = 16 + DATA_W;
   localparam int SW = $clog2(NUM_CS) + 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t            state;
   logic [N-1:0]      tx;
   logic [DATA_W-1:0] rx;
   logic              rw;
   logic [15:0]       cnt;
   logic [15:0]       div_cnt;
   logic [5:0]        bit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tx          <= '0;
         rx          <= '0;
         rw          <= 1'b0;
         cnt         <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         spi_sclk    <= 1'b0;
         spi_mosi    <= 1'b0;
         spi_mosi_oe <= 1'b0;
         spi_cs_n    <= '1;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: if (cmd_valid) begin
               cmd_ready <= 1'b0;
               busy      <= 1'b1;
               rw        <= cmd_rw;
               tx        <= {cmd_rw, 2'b00, cmd_addr, cmd_wdata & {DATA_W{!cmd_rw}}};
               rx        <= '0;
               if (cmd_cs_sel >= SW'(NUM_CS)) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= GAP;
                  cnt       <= 16'(CS_IDLE - 1);
               end else begin
                  spi_cs_n    <= ~(NUM_CS'(1) << cmd_cs_sel);
                  spi_mosi    <= cmd_rw;
                  spi_mosi_oe <= 1'b1;
                  state       <= SETUP;
                  cnt         <= 16'(CS_SETUP - 1);
               end
            end
            SETUP: if (cnt == 16'd0) begin
               state    <= SHIFT;
               spi_sclk <= 1'b1;
               rx       <= {rx[DATA_W-2:0], spi_miso};
               div_cnt  <= 16'(CLK_DIV - 1);
               bit_cnt  <= '0;
            end else begin
               cnt <= cnt - 16'd1;
            end
            SHIFT: if (div_cnt != 16'd0) begin
               div_cnt <= div_cnt - 16'd1;
            end else if (spi_sclk) begin
               spi_sclk <= 1'b0;
               div_cnt  <= 16'(CLK_DIV - 1);
               tx       <= tx << 1;
               // Reads release SDIO once the last instruction bit has been clocked.
               if (rw && bit_cnt >= 6'd15) begin
                  spi_mosi    <= 1'b0;
                  spi_mosi_oe <= 1'b0;
               end else begin
                  spi_mosi <= tx[N-2];
               end
            end else if (bit_cnt == 6'(N - 1)) begin
               state <= HOLD;
               cnt   <= 16'(CS_HOLD - 1);
            end else begin
               spi_sclk <= 1'b1;
               div_cnt  <= 16'(CLK_DIV - 1);
               bit_cnt  <= bit_cnt + 6'd1;
               rx       <= {rx[DATA_W-2:0], spi_miso};
            end
            HOLD: if (cnt == 16'd0) begin
               spi_cs_n    <= '1;
               spi_mosi    <= 1'b0;
               spi_mosi_oe <= 1'b0;
               rsp_valid   <= 1'b1;
               rsp_err     <= 1'b0;
               rsp_rdata   <= rw ? rx : '0;
               state       <= GAP;
               cnt         <= 16'(CS_IDLE - 1);
            end else begin
               cnt <= cnt - 16'd1;
            end
            GAP: if (cnt == 16'd0) begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end else begin
               cnt <= cnt - 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_ad9634_mc.sv
// tb/tb_spi_master_ad9634_mc.sv - directed self-checking bench for spi_master_ad9634_mc
module tb_spi_master_ad9634_mc;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;

   logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
   logic [12:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0, rsp_rdata;
   logic [1:0] cmd_cs_sel = '0, spi_cs_n;
   logic rsp_valid, rsp_err, busy, spi_sclk, spi_mosi, spi_mosi_oe, spi_miso;

   logic f_valid = 1'b0, f_ready, f_rw = 1'b0;
   logic [12:0] f_addr = '0;
   logic [15:0] f_wdata = '0, f_rdata;
   logic [1:0] f_sel = '0, f_cs_n;
   logic f_rsp_valid, f_err, f_busy, f_sclk, f_mosi, f_oe, f_miso;

   spi_master_ad9634_mc u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_cs_sel(cmd_cs_sel), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_mosi_oe(spi_mosi_oe), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n));

   spi_master_ad9634_mc #(.CLK_DIV(1), .DATA_W(16)) u_fast (
      .clk(clk), .rst_n(rst_n), .cmd_valid(f_valid), .cmd_ready(f_ready), .cmd_rw(f_rw),
      .cmd_addr(f_addr), .cmd_wdata(f_wdata), .cmd_cs_sel(f_sel), .rsp_valid(f_rsp_valid),
      .rsp_rdata(f_rdata), .rsp_err(f_err), .busy(f_busy), .spi_sclk(f_sclk), .spi_mosi(f_mosi),
      .spi_mosi_oe(f_oe), .spi_miso(f_miso), .spi_cs_n(f_cs_n));

   int errors = 0, checks = 0;

   // Slave model and frame recorder for the default-parameter instance.
   logic [7:0] miso_byte = '0;
   logic [23:0] mosi_cap = '0, oe_cap = '0, frame_mosi = '0, frame_oe = '0;
   logic [1:0] prev_cs = 2'b11, frame_cs = 2'b11;
   logic prev_sclk = 1'b0;
   int rises = 0, low_cnt = 0, high_cnt = 0, frames = 0, viol = 0;
   int frame_rises = 0, frame_low = 0, frame_gap = 0;
   always @(negedge clk) begin
      if ($countones(~spi_cs_n) > 1) viol++;
      if (spi_cs_n != 2'b11) begin
         if (prev_cs == 2'b11) begin frame_gap = high_cnt; frame_cs = spi_cs_n; high_cnt = 0; end
         low_cnt++;
         if (spi_sclk && !prev_sclk) begin
            rises++;
            mosi_cap = {mosi_cap[22:0], spi_mosi};
            oe_cap = {oe_cap[22:0], spi_mosi_oe};
         end
      end else begin
         if (prev_cs != 2'b11) begin
            frame_rises = rises; frame_low = low_cnt; frame_mosi = mosi_cap; frame_oe = oe_cap; frames++;
         end
         rises = 0; low_cnt = 0; mosi_cap = '0; oe_cap = '0; high_cnt++;
      end
      prev_cs = spi_cs_n;
      prev_sclk = spi_sclk;
      spi_miso = (rises + 1 >= 17 && rises + 1 <= 24) ? miso_byte[24 - (rises + 1)] : 1'b0;
   end

   // Slave model for the fast instance (32-bit frame, 16 data bits).
   logic [15:0] resp2 = '0;
   logic prev_sclk2 = 1'b0;
   int rises2 = 0, frame2_rises = 0, cyc2 = 0, first2 = 0, second2 = 0;
   always @(negedge clk) begin
      cyc2++;
      if (f_cs_n == 2'b11) begin
         if (rises2 != 0) frame2_rises = rises2;
         rises2 = 0;
      end else if (f_sclk && !prev_sclk2) begin
         rises2++;
         if (rises2 == 1) first2 = cyc2;
         if (rises2 == 2) second2 = cyc2;
      end
      prev_sclk2 = f_sclk;
      f_miso = (rises2 + 1 >= 17 && rises2 + 1 <= 32) ? resp2[32 - (rises2 + 1)] : 1'b0;
   end

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 2000);
      if (!rsp_valid) lat = -1;
   endtask

   task automatic do_cmd(input logic rw, input logic [12:0] addr, input logic [7:0] wd,
                         input logic [1:0] sel, output int lat);
      int n;
      cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_cs_sel = sel; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_rsp(lat);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({cmd_ready, busy, rsp_valid, rsp_err, spi_sclk, spi_mosi, spi_mosi_oe, spi_cs_n} !== 9'b100000011) begin errors++; $display("FAIL reset_ctl: got %b expected %b", {cmd_ready, busy, rsp_valid, rsp_err, spi_sclk, spi_mosi, spi_mosi_oe, spi_cs_n}, 9'b100000011); end
      checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write;
      int lat;
      do_cmd(1'b0, 13'h008, 8'h03, 2'd0, lat);
      checks++; if (lat !== 197) begin errors++; $display("FAIL wr_latency: got %0d expected 197", lat); end
      checks++; if ({rsp_err, rsp_rdata} !== 9'h000) begin errors++; $display("FAIL wr_rsp: got err=%b rdata=%h expected 0/00", rsp_err, rsp_rdata); end
      repeat (2) @(negedge clk);
      checks++; if (frame_mosi !== 24'h000803) begin errors++; $display("FAIL wr_mosi: got %h expected 000803", frame_mosi); end
      checks++; if (frame_rises !== 24) begin errors++; $display("FAIL wr_rises: got %0d expected 24", frame_rises); end
      checks++; if (frame_low !== 196) begin errors++; $display("FAIL wr_cs_low: got %0d expected 196", frame_low); end
      checks++; if (frame_cs !== 2'b10) begin errors++; $display("FAIL wr_cs_sel: got %b expected 10", frame_cs); end
      checks++; if (frame_oe !== 24'hFFFFFF) begin errors++; $display("FAIL wr_oe: got %h expected FFFFFF", frame_oe); end
   endtask

   task automatic test_read;
      int lat;
      miso_byte = 8'hA5;
      do_cmd(1'b1, 13'h001, 8'hFF, 2'd1, lat);
      checks++; if (lat !== 197) begin errors++; $display("FAIL rd_latency: got %0d expected 197", lat); end
      checks++; if ({rsp_err, rsp_rdata} !== 9'h0A5) begin errors++; $display("FAIL rd_rsp: got err=%b rdata=%h expected 0/A5", rsp_err, rsp_rdata); end
      repeat (2) @(negedge clk);
      checks++; if (frame_mosi !== 24'h800100) begin errors++; $display("FAIL rd_mosi: got %h expected 800100", frame_mosi); end
      checks++; if (frame_oe !== 24'hFFFF00) begin errors++; $display("FAIL rd_oe: got %h expected FFFF00", frame_oe); end
      checks++; if (frame_cs !== 2'b01) begin errors++; $display("FAIL rd_cs_sel: got %b expected 01", frame_cs); end
   endtask

   task automatic test_bad_sel;
      int lat, n, f0;
      f0 = frames;
      do_cmd(1'b1, 13'h001, 8'h00, 2'd2, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL bad_latency: got %0d expected 1", lat); end
      checks++; if ({rsp_err, rsp_rdata} !== 9'h100) begin errors++; $display("FAIL bad_rsp: got err=%b rdata=%h expected 1/00", rsp_err, rsp_rdata); end
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      checks++; if (n !== 4) begin errors++; $display("FAIL bad_ready_gap: got %0d expected 4", n); end
      checks++; if (frames !== f0) begin errors++; $display("FAIL bad_cs_activity: got %0d frames expected %0d", frames, f0); end
   endtask

   task automatic test_back_to_back;
      int lat, n;
      miso_byte = 8'h3C;
      cmd_rw = 1'b0; cmd_addr = 13'h010; cmd_wdata = 8'h5A; cmd_cs_sel = 2'd0; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_rw = 1'b1; cmd_addr = 13'h002; cmd_wdata = 8'hFF; cmd_cs_sel = 2'd1;
      wait_rsp(lat);
      checks++; if (lat !== 197) begin errors++; $display("FAIL b2b1_latency: got %0d expected 197", lat); end
      checks++; if ({rsp_err, rsp_rdata} !== 9'h000) begin errors++; $display("FAIL b2b1_rsp: got err=%b rdata=%h expected 0/00", rsp_err, rsp_rdata); end
      repeat (2) @(negedge clk);
      checks++; if ({frame_cs, frame_mosi} !== {2'b10, 24'h00105A}) begin errors++; $display("FAIL b2b1_frame: got cs=%b mosi=%h expected 10/00105A", frame_cs, frame_mosi); end
      n = 0;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_rsp(lat);
      checks++; if (lat !== 197) begin errors++; $display("FAIL b2b2_latency: got %0d expected 197", lat); end
      checks++; if ({rsp_err, rsp_rdata} !== 9'h03C) begin errors++; $display("FAIL b2b2_rsp: got err=%b rdata=%h expected 0/3C", rsp_err, rsp_rdata); end
      repeat (2) @(negedge clk);
      checks++; if (frame_gap !== 5) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected 5", frame_gap); end
      checks++; if ({frame_cs, frame_mosi} !== {2'b01, 24'h800200}) begin errors++; $display("FAIL b2b2_frame: got cs=%b mosi=%h expected 01/800200", frame_cs, frame_mosi); end
   endtask

   task automatic test_reset_mid;
      int lat, pulses;
      cmd_rw = 1'b0; cmd_addr = 13'h0AA; cmd_wdata = 8'h55; cmd_cs_sel = 2'd0; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({cmd_ready, busy, rsp_valid, rsp_err, spi_sclk, spi_mosi, spi_mosi_oe, spi_cs_n} !== 9'b100000011) begin errors++; $display("FAIL midrst_ctl: got %b expected %b", {cmd_ready, busy, rsp_valid, rsp_err, spi_sclk, spi_mosi, spi_mosi_oe, spi_cs_n}, 9'b100000011); end
      pulses = 0;
      repeat (5) begin @(negedge clk); if (rsp_valid) pulses++; end
      rst_n = 1'b1;
      repeat (300) begin @(negedge clk); if (rsp_valid) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d pulses expected 0", pulses); end
      do_cmd(1'b0, 13'h1FFF, 8'hFF, 2'd1, lat);
      checks++; if (lat !== 197) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 197", lat); end
      repeat (2) @(negedge clk);
      checks++; if ({frame_cs, frame_mosi} !== {2'b01, 24'h1FFFFF}) begin errors++; $display("FAIL midrst_next_frame: got cs=%b mosi=%h expected 01/1FFFFF", frame_cs, frame_mosi); end
   endtask

   task automatic test_fast;
      int lat;
      resp2 = 16'h1234;
      f_rw = 1'b1; f_addr = 13'h003; f_wdata = 16'hFFFF; f_sel = 2'd0; f_valid = 1'b1;
      @(posedge clk); #1;
      f_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!f_rsp_valid && lat < 500);
      checks++; if (lat !== 69) begin errors++; $display("FAIL fast_latency: got %0d expected 69", lat); end
      checks++; if ({f_err, f_rdata} !== 17'h01234) begin errors++; $display("FAIL fast_rsp: got err=%b rdata=%h expected 0/1234", f_err, f_rdata); end
      repeat (2) @(negedge clk);
      checks++; if (frame2_rises !== 32) begin errors++; $display("FAIL fast_rises: got %0d expected 32", frame2_rises); end
      checks++; if (second2 - first2 !== 2) begin errors++; $display("FAIL fast_period: got %0d expected 2", second2 - first2); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_sel();
      test_back_to_back();
      test_reset_mid();
      test_fast();
      checks++; if (viol !== 0) begin errors++; $display("FAIL cs_onehot: got %0d violations expected 0", viol); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
